// File: rtl/print_uart_tx_pkg.sv
// Shared constants for the console UART transmitter: FSM state encodings,
// 8N1 frame geometry and the field layout of the core's print word.
package print_uart_tx_pkg;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_START = 2'd1;
  localparam logic [1:0] ST_DATA  = 2'd2;
  localparam logic [1:0] ST_STOP  = 2'd3;

  // 8N1: one start bit, eight data bits, one stop bit.
  localparam int FRAME_BITS = 10;
  localparam int DATA_BITS  = FRAME_BITS - 2;

  localparam int PRINT_W   = 49;
  localparam int VALID_BIT = 48;
  localparam int CHAR_MSB  = 7;
  localparam int CHAR_LSB  = 0;

endpackage

// File: rtl/print_fifo.sv
// Byte FIFO between the print port and the serializer. The caller qualifies
// push and pop against count, so this block never sees an illegal request.
module print_fifo #(
  parameter int DEPTH = 16
) (
  input  logic                       clk,
  input  logic                       resetn,
  input  logic                       push,
  input  logic                       pop,
  input  logic [7:0]                 din,
  output logic [7:0]                 dout,
  output logic [$clog2(DEPTH+1)-1:0] count
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH+1);

  logic [7:0]    mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;

  // NOTE: storage has no reset; count and pointers alone define what is valid,
  // which keeps the array a plain RAM without a reset fan-out.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= din;
  end

  // NOTE: every sequential assignment is non-blocking so all registers update
  // from the same pre-edge values, independent of statement order.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      // DEPTH is a power of two, so pointer overflow wraps modulo DEPTH.
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop)  rd_ptr <= rd_ptr + AW'(1);
      case ({push, pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

  assign dout = mem[rd_ptr];

endmodule

// File: rtl/print_uart_tx.sv
// Console UART transmitter: buffers characters from the core's print word and
// sends them as 8N1 frames, LSB first, with a registered glitch-free tx line.
module print_uart_tx
  import print_uart_tx_pkg::*;
#(
  parameter int CLK_DIV    = 868,
  parameter int FIFO_DEPTH = 16
) (
  input  logic                            clk,
  input  logic                            resetn,
  input  logic [PRINT_W-1:0]              print_in,
  output logic                            tx,
  output logic                            busy,
  output logic                            overflow,
  output logic [$clog2(FIFO_DEPTH+1)-1:0] fifo_count
);

  localparam int          CW          = $clog2(FIFO_DEPTH+1);
  localparam logic [15:0] BAUD_RELOAD = 16'(CLK_DIV - 1);
  localparam logic [2:0]  LAST_BIT    = 3'(DATA_BITS - 1);

  logic [1:0]  state;
  logic [15:0] baud_cnt;
  logic [2:0]  bit_idx;
  logic [7:0]  shift_reg;
  logic [7:0]  head;
  logic        valid;
  logic        bit_done;
  logic        fifo_full;
  logic        fifo_empty;
  logic        push;
  logic        pop;
  logic        unused_payload;

  assign valid          = print_in[VALID_BIT];
  assign unused_payload = ^print_in[VALID_BIT-1:CHAR_MSB+1];
  assign bit_done       = (baud_cnt == 16'd0);
  assign fifo_full      = (fifo_count == CW'(FIFO_DEPTH));
  assign fifo_empty     = (fifo_count == '0);

  // A pop frees a slot on the same edge, so a full FIFO can still accept then.
  assign pop  = !fifo_empty && ((state == ST_IDLE) || (state == ST_STOP && bit_done));
  assign push = valid && (!fifo_full || pop);
  assign busy = (state != ST_IDLE) || !fifo_empty;

  print_fifo #(
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk    (clk),
    .resetn (resetn),
    .push   (push),
    .pop    (pop),
    .din    (print_in[CHAR_MSB:CHAR_LSB]),
    .dout   (head),
    .count  (fifo_count)
  );

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state     <= ST_IDLE;
      baud_cnt  <= '0;
      bit_idx   <= '0;
      shift_reg <= '0;
      tx        <= 1'b1;
    end else begin
      case (state)
        ST_IDLE: begin
          if (pop) begin
            shift_reg <= head;
            baud_cnt  <= BAUD_RELOAD;
            tx        <= 1'b0;
            state     <= ST_START;
          end
        end
        ST_START: begin
          if (bit_done) begin
            baud_cnt <= BAUD_RELOAD;
            bit_idx  <= '0;
            tx       <= shift_reg[0];
            state    <= ST_DATA;
          end else begin
            baud_cnt <= baud_cnt - 16'd1;
          end
        end
        ST_DATA: begin
          if (bit_done) begin
            baud_cnt  <= BAUD_RELOAD;
            shift_reg <= shift_reg >> 1;
            if (bit_idx == LAST_BIT) begin
              tx    <= 1'b1;
              state <= ST_STOP;
            end else begin
              bit_idx <= bit_idx + 3'd1;
              tx      <= shift_reg[1];
            end
          end else begin
            baud_cnt <= baud_cnt - 16'd1;
          end
        end
        ST_STOP: begin
          if (bit_done) begin
            // Chain straight into the next start bit when more bytes wait.
            if (pop) begin
              shift_reg <= head;
              baud_cnt  <= BAUD_RELOAD;
              tx        <= 1'b0;
              state     <= ST_START;
            end else begin
              state <= ST_IDLE;
            end
          end else begin
            baud_cnt <= baud_cnt - 16'd1;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn)                                    overflow <= 1'b0;
    else if (valid && fifo_full && !pop)            overflow <= 1'b1;
  end

endmodule

// File: tb/tb_print_uart_tx.sv
// Directed bench for print_uart_tx at CLK_DIV=4, FIFO_DEPTH=4: a vector table
// for idle/first-push behaviour plus cycle-exact frame sequences.
module tb_print_uart_tx;

  localparam int CLK_DIV    = 4;
  localparam int FIFO_DEPTH = 4;
  localparam int FRAME_CYC  = 10 * CLK_DIV;

  logic        clk = 1'b0;
  logic        resetn;
  logic [48:0] print_in;
  logic        tx;
  logic        busy;
  logic        overflow;
  logic [2:0]  fifo_count;

  int checks = 0;
  int errors = 0;
  int peak   = 0;

  logic [48:0] inj [FRAME_CYC];

  typedef struct {
    logic [48:0] din;
    logic        tx;
    logic [2:0]  cnt;
    logic        busy;
    logic        ovf;
  } vec_t;

  vec_t vecs [5];

  print_uart_tx #(
    .CLK_DIV    (CLK_DIV),
    .FIFO_DEPTH (FIFO_DEPTH)
  ) dut (
    .clk        (clk),
    .resetn     (resetn),
    .print_in   (print_in),
    .tx         (tx),
    .busy       (busy),
    .overflow   (overflow),
    .fifo_count (fifo_count)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic clear_inj();
    for (int k = 0; k < FRAME_CYC; k++) inj[k] = '0;
  endtask

  function automatic logic [48:0] pw(input logic [7:0] c);
    return {1'b1, 40'h0, c};
  endfunction

  // Entered at the first sample of the start bit; checks tx for n cycles,
  // applying inj[k] as print_in for the edge that follows sample k.
  task automatic expect_frame(input logic [7:0] c, input int n, input string tag);
    logic exp_bit;
    for (int k = 0; k < n; k++) begin
      if (k < CLK_DIV)                 exp_bit = 1'b0;
      else if (k >= 9 * CLK_DIV)       exp_bit = 1'b1;
      else                             exp_bit = c[k / CLK_DIV - 1];
      check($sformatf("%s tx k%0d", tag, k), tx, exp_bit);
      if (int'(fifo_count) > peak) peak = int'(fifo_count);
      print_in = inj[k];
      tick();
    end
    print_in = '0;
    clear_inj();
  endtask

  initial begin
    resetn   = 1'b0;
    print_in = '0;
    clear_inj();

    vecs[0] = '{49'h0_FFFF_FFFF_FF41, 1'b1, 3'd0, 1'b0, 1'b0};
    vecs[1] = '{49'h0_1234_5678_9ABC, 1'b1, 3'd0, 1'b0, 1'b0};
    vecs[2] = '{49'h0_0000_0000_00FF, 1'b1, 3'd0, 1'b0, 1'b0};
    vecs[3] = '{49'h1_0000_0000_0041, 1'b1, 3'd1, 1'b1, 1'b0};
    vecs[4] = '{49'h0_0000_0000_0000, 1'b0, 3'd0, 1'b1, 1'b0};

    // Reset state
    repeat (2) tick();
    check("rst tx", tx, 1'b1);
    check("rst count", fifo_count, 3'd0);
    check("rst busy", busy, 1'b0);
    check("rst ovf", overflow, 1'b0);
    resetn = 1'b1;

    // Invalid words are ignored; a valid 'A' is pushed then popped next edge.
    for (int i = 0; i < 5; i++) begin
      print_in = vecs[i].din;
      tick();
      check($sformatf("vec%0d tx", i), tx, vecs[i].tx);
      check($sformatf("vec%0d count", i), fifo_count, vecs[i].cnt);
      check($sformatf("vec%0d busy", i), busy, vecs[i].busy);
      check($sformatf("vec%0d ovf", i), overflow, vecs[i].ovf);
    end
    expect_frame(8'h41, FRAME_CYC, "A");
    check("A busy after", busy, 1'b0);

    // Three back-to-back characters: no gap between frames, peak depth 2.
    peak = 0;
    print_in = pw(8'h48); tick();
    print_in = pw(8'h69); tick();
    check("hi count at start", fifo_count, 3'd1);
    inj[0] = pw(8'h0A);
    expect_frame(8'h48, FRAME_CYC, "H");
    expect_frame(8'h69, FRAME_CYC, "i");
    expect_frame(8'h0A, FRAME_CYC, "LF");
    check("hi busy after", busy, 1'b0);
    check("hi peak", peak, 2);
    check("hi ovf", overflow, 1'b0);

    // Six consecutive pushes: five accepted, the sixth dropped with overflow.
    peak = 0;
    print_in = pw(8'h31); tick();
    print_in = pw(8'h32); tick();
    inj[0] = pw(8'h33);
    inj[1] = pw(8'h34);
    inj[2] = pw(8'h35);
    inj[3] = pw(8'h36);
    expect_frame(8'h31, FRAME_CYC, "ovf c0");
    check("ovf set", overflow, 1'b1);
    check("ovf peak", peak, 4);
    expect_frame(8'h32, FRAME_CYC, "ovf c1");
    expect_frame(8'h33, FRAME_CYC, "ovf c2");
    expect_frame(8'h34, FRAME_CYC, "ovf c3");
    expect_frame(8'h35, FRAME_CYC, "ovf c4");
    check("ovf drained busy", busy, 1'b0);
    check("ovf sticky", overflow, 1'b1);

    // Reset during data bit 3 with two bytes still buffered.
    print_in = pw(8'h55); tick();
    print_in = pw(8'hAA); tick();
    inj[0] = pw(8'h0F);
    expect_frame(8'h55, 18, "abort");
    check("abort count before", fifo_count, 3'd2);
    resetn = 1'b0;
    #1;
    check("abort tx", tx, 1'b1);
    check("abort count", fifo_count, 3'd0);
    check("abort ovf", overflow, 1'b0);
    check("abort busy", busy, 1'b0);
    tick();
    resetn = 1'b1;
    for (int i = 0; i < 12; i++) begin
      tick();
      check($sformatf("post-abort idle tx %0d", i), tx, 1'b1);
    end
    check("post-abort busy", busy, 1'b0);

    // First valid edge after release is captured.
    resetn = 1'b0;
    tick();
    resetn   = 1'b1;
    print_in = pw(8'h7E);
    tick();
    check("release capture", fifo_count, 3'd1);
    print_in = '0;
    tick();
    expect_frame(8'h7E, FRAME_CYC, "release");

    // Full FIFO: a push coinciding with the stop-bit pop is accepted.
    print_in = pw(8'hC0); tick();
    print_in = pw(8'hC1); tick();
    inj[0] = pw(8'hC2);
    inj[1] = pw(8'hC3);
    inj[2] = pw(8'hC4);
    inj[FRAME_CYC-1] = pw(8'hE7);
    expect_frame(8'hC0, FRAME_CYC, "full c0");
    check("full same-edge count", fifo_count, 3'd4);
    check("full same-edge ovf", overflow, 1'b0);
    expect_frame(8'hC1, FRAME_CYC, "full c1");
    expect_frame(8'hC2, FRAME_CYC, "full c2");
    expect_frame(8'hC3, FRAME_CYC, "full c3");
    expect_frame(8'hC4, FRAME_CYC, "full c4");
    expect_frame(8'hE7, FRAME_CYC, "full late");
    check("full drained count", fifo_count, 3'd0);
    check("full drained busy", busy, 1'b0);
    check("full ovf final", overflow, 1'b0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/print_uart_tx.md
PRINT_UART_TX -- requirements
Module: print_uart_tx

Interface
REQ-001 SHALL have parameter CLK_DIV, default 868, clock cycles per UART bit (legal range 2..65535).
REQ-002 SHALL have parameter FIFO_DEPTH, default 16, byte buffer depth (power of two, at least 2).
REQ-003 SHALL have port clk  input  1  single clock; all state on rising edge.
REQ-004 SHALL have port resetn  input  1  reset, asynchronous assert, active-low.
REQ-005 SHALL have port print_in  input  49  console word from the core wrapper: bit 48 valid, bits 7:0 character, bits 47:8 ignored.
REQ-006 SHALL have port tx  output  1  UART serial line, 8N1, LSB first, idle high.
REQ-007 SHALL have port busy  output  1  high while a frame is on the line or the FIFO is non-empty.
REQ-008 SHALL have port overflow  output  1  sticky flag, set when a valid character is dropped.
REQ-009 SHALL have port fifo_count  output  $clog2(FIFO_DEPTH+1)  number of bytes buffered.

Function
REQ-010 SHALL push print_in[7:0] into the FIFO on every clk edge where print_in[48]=1 and the FIFO is not full; each valid cycle is a distinct character, and back-to-back valid cycles are all captured.
REQ-011 SHALL drop the character and set overflow when print_in[48]=1 and the FIFO is full with no pop on the same edge; overflow stays set until reset.
REQ-012 SHALL accept the push when full and a pop occurs on the same edge; fifo_count is then unchanged.
REQ-013 SHALL implement FSM states IDLE, START, DATA, STOP.
REQ-014 IDLE: tx=1; when fifo_count>0, pop the head byte into a shift register, load the baud counter with CLK_DIV-1, and enter START on the same edge.
REQ-015 START: tx=0 for CLK_DIV cycles, then enter DATA with bit index 0.
REQ-016 DATA: tx=shift[0] for CLK_DIV cycles per bit; shift right after each bit; after bit index 7 completes, enter STOP.
REQ-017 STOP: tx=1 for CLK_DIV cycles; at completion, if fifo_count>0, pop and enter START directly (no idle cycle); otherwise enter IDLE.
REQ-018 SHALL drive tx from a register (glitch-free); a frame SHALL occupy exactly 10*CLK_DIV cycles.
REQ-019 Latency: a character sampled at edge N into an empty FIFO with FSM in IDLE SHALL drive tx low from edge N+1.
REQ-020 The baud counter SHALL be 16 bits, count down, and reload at each bit boundary; no fractional divide.
REQ-021 busy SHALL be combinational: (state!=IDLE) or (fifo_count!=0).
REQ-022 FIFO read and write pointers SHALL wrap modulo FIFO_DEPTH; full is fifo_count==FIFO_DEPTH and empty is fifo_count==0.

Reset
REQ-023 On resetn=0, asynchronously: state=IDLE, tx=1, FIFO empty, fifo_count=0, overflow=0, counters=0, shift register=0.
REQ-024 Reset asserted mid-frame SHALL abort the frame and return tx high immediately; buffered characters are discarded.
REQ-025 After resetn deasserts, the first character SHALL be accepted on the first edge where it is valid.

Structure
REQ-026 A shared package SHALL hold the FSM state enumeration, the 8N1 frame constants (data bits 8, frame bits 10), and the print word field positions (valid bit 48, char bits 7:0).
REQ-027 The byte FIFO SHALL be a sub-module print_fifo (parameter DEPTH; push/pop/din/dout/count ports; same clock and reset).

Verification (CLK_DIV=4, FIFO_DEPTH=4)
REQ-028 Reset release, then print_in=49'h1_0000_0000_0041 for one cycle -> tx low from the next edge; bits 1,0,0,0,0,0,1,0 then 1, each 4 cycles; 40 cycles total; busy drops after the stop bit.
REQ-029 Three consecutive valid cycles with chars 0x48, 0x69, 0x0A -> three frames back-to-back with no idle gap (120 cycles); fifo_count peaks at 2.
REQ-030 Six consecutive valid cycles while idle -> first char popped and 4 buffered, 6th accepted only if a pop coincides, else dropped with overflow=1; decoded output matches the accepted set.
REQ-031 print_in[48]=0 with nonzero bits 47:0 -> no push, tx stays 1, fifo_count=0.
REQ-032 resetn pulsed low during DATA bit 3 with 2 bytes buffered -> tx=1 immediately, fifo_count=0, overflow=0, no frame after release.
REQ-033 Full FIFO with simultaneous valid input and stop-bit completion (pop) -> character accepted, fifo_count unchanged, overflow stays 0.
